fwd_hazard_unit: RTL and testbench

- Tracks the two instructions downstream of EX (EX/MEM and MEM/WB slots).
- Drives the 2-bit select of the ALU-operand 3:1 muxes (00 = register file, 01 = EX/MEM result, 10 = MEM/WB writeback value).
- Supplies the B and C data inputs of those muxes.
- Raises a load-use stall and a memory-wait stall toward pipeline control.
- Sits between decode/EX control and the operand muxes feeding the ALU.

---
 rtl/fwd_hazard_unit_pkg.sv | 37 +++
 rtl/fwd_hazard_unit_match.sv | 35 +++
 rtl/fwd_hazard_unit.sv | 108 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Slot structs mirror the EX/MEM and MEM/WB pipeline registers tracked by the unit.
package fwd_hazard_unit_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            is_load;
        logic [XLEN-1:0] result;
    } mem_slot_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic [XLEN-1:0] data;
    } wb_slot_t;

    // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
    function automatic logic rd_hit(input logic            valid,
                                    input logic            regwrite,
                                    input logic [RA_W-1:0] rd,
                                    input logic [RA_W-1:0] rs);
        return valid & regwrite & (rd != '0) & (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Per-operand comparator: picks register file, EX/MEM result or MEM/WB value.
// A load still in MEM has no data yet, so it is never a MEM-stage forwarding source.
module fwd_match
    import fwd_hazard_unit_pkg::*;
(
    input  logic            ex_valid_i,
    input  logic [RA_W-1:0] rs_i,
    input  logic            mem_valid_i,
    input  logic            mem_regwrite_i,
    input  logic            mem_is_load_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            wb_valid_i,
    input  logic            wb_regwrite_i,
    input  logic [RA_W-1:0] wb_rd_i,
    output fwd_sel_t        sel_o
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = rd_hit(mem_valid_i, mem_regwrite_i & ~mem_is_load_i, mem_rd_i, rs_i);
    assign hit_wb  = rd_hit(wb_valid_i, wb_regwrite_i, wb_rd_i, rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_valid_i) begin
            if (hit_mem) begin
                sel_o = FWD_MEM;
            end else if (hit_wb) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks the EX/MEM and MEM/WB slots, drives the ALU
// operand mux selects and data, and raises load-use and memory-wait stalls.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            ex_valid,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [1:0]      fwd_sel_a,
    output logic [1:0]      fwd_sel_b,
    output logic [XLEN-1:0] fwd_mem_data,
    output logic [XLEN-1:0] fwd_wb_data,
    output logic            load_use_stall,
    output logic            mem_stall,
    output logic            wb_valid,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data
);

    mem_slot_t mem_q, mem_d;
    wb_slot_t  wb_q,  wb_d;
    fwd_sel_t  sel_a, sel_b;
    logic      ex_load_dst;

    assign mem_stall = mem_q.valid & mem_q.is_load & ~mem_ready;

    // During a memory wait MEM holds the load and WB drains as a bubble.
    always_comb begin
        mem_d = mem_q;
        wb_d  = wb_q;
        if (mem_stall) begin
            wb_d.valid = 1'b0;
        end else begin
            wb_d.valid    = mem_q.valid;
            wb_d.rd       = mem_q.rd;
            wb_d.regwrite = mem_q.regwrite;
            wb_d.data     = mem_q.is_load ? mem_rdata : mem_q.result;
            mem_d.valid    = ex_valid;
            mem_d.rd       = ex_rd;
            mem_d.regwrite = ex_regwrite;
            mem_d.is_load  = ex_is_load;
            mem_d.result   = ex_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    fwd_match u_match_a (
        .ex_valid_i     (ex_valid),
        .rs_i           (ex_rs1),
        .mem_valid_i    (mem_q.valid),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_is_load_i  (mem_q.is_load),
        .mem_rd_i       (mem_q.rd),
        .wb_valid_i     (wb_q.valid),
        .wb_regwrite_i  (wb_q.regwrite),
        .wb_rd_i        (wb_q.rd),
        .sel_o          (sel_a)
    );

    fwd_match u_match_b (
        .ex_valid_i     (ex_valid),
        .rs_i           (ex_rs2),
        .mem_valid_i    (mem_q.valid),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_is_load_i  (mem_q.is_load),
        .mem_rd_i       (mem_q.rd),
        .wb_valid_i     (wb_q.valid),
        .wb_regwrite_i  (wb_q.regwrite),
        .wb_rd_i        (wb_q.rd),
        .sel_o          (sel_b)
    );

    assign fwd_sel_a = sel_a;
    assign fwd_sel_b = sel_b;

    assign ex_load_dst    = ex_valid & ex_is_load & ex_regwrite & (ex_rd != '0);
    assign load_use_stall = ex_load_dst &
                            ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                             (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign fwd_mem_data = mem_q.result;
    assign fwd_wb_data  = wb_q.data;
    assign wb_data      = wb_q.data;
    assign wb_rd        = wb_q.rd;
    assign wb_valid     = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic [RA_W-1:0] id_rs1, id_rs2;
    logic            id_uses_rs1, id_uses_rs2;
    logic            ex_valid;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic            ex_regwrite, ex_is_load;
    logic [XLEN-1:0] ex_result, mem_rdata;
    logic            mem_ready;
    logic [1:0]      fwd_sel_a, fwd_sel_b;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data, wb_data;
    logic            load_use_stall, mem_stall, wb_valid;
    logic [RA_W-1:0] wb_rd;

    fwd_hazard_unit dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_is_load     (ex_is_load),
        .ex_result      (ex_result),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .fwd_sel_a      (fwd_sel_a),
        .fwd_sel_b      (fwd_sel_b),
        .fwd_mem_data   (fwd_mem_data),
        .fwd_wb_data    (fwd_wb_data),
        .load_use_stall (load_use_stall),
        .mem_stall      (mem_stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] md;
        logic [31:0] wd;
        logic        lus;
        logic        mst;
        logic        wbv;
        logic [4:0]  wrd;
        bit          chk_wb;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string nm, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, "fwd_sel_a",      32'(fwd_sel_a),      32'(e.sa));
            check(e.name, "fwd_sel_b",      32'(fwd_sel_b),      32'(e.sb));
            check(e.name, "fwd_mem_data",   fwd_mem_data,        e.md);
            check(e.name, "load_use_stall", 32'(load_use_stall), 32'(e.lus));
            check(e.name, "mem_stall",      32'(mem_stall),      32'(e.mst));
            check(e.name, "wb_valid",       32'(wb_valid),       32'(e.wbv));
            if (e.chk_wb) begin
                check(e.name, "fwd_wb_data", fwd_wb_data, e.wd);
                check(e.name, "wb_data",     wb_data,     e.wd);
                check(e.name, "wb_rd",       32'(wb_rd),  32'(e.wrd));
            end
        end
    end

    // A load sitting in MEM must never feed a valid EX instruction directly.
    always @(negedge clk) begin
        if (!reset && ex_valid && dut.mem_q.valid && dut.mem_q.is_load && dut.mem_q.rd != '0) begin
            assert (dut.mem_q.rd != ex_rs1 && dut.mem_q.rd != ex_rs2)
                else $error("load in MEM matched an EX source register");
        end
    end

    task automatic set_ex(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic rw, input logic ld,
                          input logic [31:0] res);
        ex_valid    = v;
        ex_rs1      = r1;
        ex_rs2      = r2;
        ex_rd       = rd;
        ex_regwrite = rw;
        ex_is_load  = ld;
        ex_result   = res;
    endtask

    task automatic set_id(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2);
        id_rs1      = r1;
        id_rs2      = r2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
    endtask

    task automatic issue(input string nm, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [31:0] md, input logic [31:0] wd,
                         input logic lus, input logic mst, input logic wbv,
                         input logic [4:0] wrd, input bit cwb);
        exp_t e;
        e.name = nm; e.sa = sa; e.sb = sb; e.md = md; e.wd = wd;
        e.lus = lus; e.mst = mst; e.wbv = wbv; e.wrd = wrd; e.chk_wb = cwb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = '0;
        set_ex(0, 0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        issue("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;

        // back-to-back dependency
        set_ex(1, 1, 2, 5, 1, 0, 32'h42);     issue("b2b_prod", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        set_ex(1, 5, 6, 8, 1, 0, 32'h100);    issue("b2b_cons", 1, 0, 32'h42, 0, 0, 0, 0, 0, 1);
        // distance-2 dependency, plus bubble suppressing a match
        set_ex(1, 0, 0, 7, 1, 0, 32'h1234);   issue("d2_prod", 0, 0, 32'h100, 32'h42, 0, 0, 1, 5, 1);
        set_ex(0, 7, 7, 0, 0, 0, 0);          issue("bubble_nofwd", 0, 0, 32'h1234, 32'h100, 0, 0, 1, 8, 1);
        set_ex(1, 1, 7, 9, 1, 0, 32'h55);     issue("d2_cons", 0, 2, 0, 32'h1234, 0, 0, 1, 7, 1);
        // MEM over WB priority
        set_ex(1, 0, 0, 3, 1, 0, 32'hBB);     issue("prio_old", 0, 0, 32'h55, 0, 0, 0, 0, 0, 1);
        set_ex(1, 0, 0, 3, 1, 0, 32'hAA);     issue("prio_new", 0, 0, 32'hBB, 32'h55, 0, 0, 1, 9, 1);
        set_ex(1, 3, 3, 0, 0, 0, 0);          issue("prio_mem", 1, 1, 32'hAA, 32'hBB, 0, 0, 1, 3, 1);
        set_ex(1, 3, 0, 0, 1, 0, 32'h77);     issue("wb_only", 2, 0, 0, 32'hAA, 0, 0, 1, 3, 1);
        // x0 in both slots
        set_ex(1, 0, 0, 0, 1, 0, 32'h66);     issue("x0_prod", 0, 0, 32'h77, 0, 0, 0, 0, 0, 1);
        set_ex(1, 0, 0, 0, 0, 0, 0);          issue("x0_cons", 0, 0, 32'h66, 32'h77, 0, 0, 0, 0, 1);
        // load-use
        set_ex(1, 2, 0, 4, 1, 1, 32'h1000); set_id(4, 0, 1, 0);
        issue("lu_detect", 0, 0, 0, 32'h66, 1, 0, 0, 0, 1);
        set_ex(0, 0, 0, 0, 0, 0, 0); mem_rdata = 32'hDEAD_BEEF;
        issue("lu_bubble", 0, 0, 32'h1000, 0, 0, 0, 0, 0, 1);
        set_ex(1, 4, 0, 10, 1, 0, 32'h200); set_id(0, 0, 0, 0); mem_rdata = '0;
        issue("lu_cons", 2, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 4, 1);
        // memory wait
        set_ex(1, 0, 0, 6, 1, 1, 32'h2000);   issue("mw_load", 0, 0, 32'h200, 0, 0, 0, 0, 0, 1);
        mem_ready = 1'b0; set_ex(1, 1, 2, 11, 1, 0, 32'h300);
        issue("mw_wait1", 0, 0, 32'h2000, 32'h200, 0, 1, 1, 10, 1);
        issue("mw_wait2", 0, 0, 32'h2000, 0, 0, 1, 0, 0, 0);
        issue("mw_wait3", 0, 0, 32'h2000, 0, 0, 1, 0, 0, 0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        issue("mw_done", 0, 0, 32'h2000, 0, 0, 0, 0, 0, 0);
        mem_rdata = '0; set_ex(1, 11, 6, 12, 1, 0, 32'h400);
        issue("mw_after", 1, 2, 32'h300, 32'hCAFE_F00D, 0, 0, 1, 6, 1);
        // reset with both slots valid
        reset = 1'b1; set_ex(1, 12, 11, 13, 1, 0, 32'h500);
        issue("pre_reset", 1, 2, 32'h400, 32'h300, 0, 0, 1, 11, 1);
        reset = 1'b0;
        issue("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        set_ex(0, 0, 0, 0, 0, 0, 0);
        issue("no_wb_after_reset", 0, 0, 32'h500, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
